// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry helpers for the set-associative
// data cache controller.
//   state_t : controller state (IDLE, WRITEBACK, REFILL, DONE)
//   off_w   : byte-offset width of a cache line
//   idx_w   : set-index width
//   tag_w   : tag width left over from the byte address
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_w, input int sets);
    return addr_w - idx_w(sets) - off_w(line_w);
  endfunction

endpackage

// File: rtl/dcache_way_store.sv
// dcache_way_store: one way of the cache -- tag, valid, dirty and line data
// for every set.
//   clk, rst   : clock, asynchronous active-high reset (clears valid/dirty)
//   idx        : set index shared by the read port and both write ports
//   valid/dirty/tag/line : combinational read of set idx
//   line_we    : install line_data/line_tag, set valid, clear dirty
//   word_we    : merge word_data into word word_sel of the line, set dirty
// line_we and word_we are never asserted together by the controller.
module dcache_way_store #(
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  parameter int IDX_W  = 4,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] line,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [LINE_W-1:0] line_data,
  input  logic              word_we,
  input  logic [SEL_W-1:0]  word_sel,
  input  logic [WORD_W-1:0] word_data
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign line  = data_q[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tags and data need no reset: they are only observed through valid.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx]  <= line_tag;
      data_q[idx] <= line_data;
    end else if (word_we) begin
      data_q[idx][word_sel*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_assoc_ctrl.sv
// dcache_assoc_ctrl: set-associative, write-back, write-allocate data cache
// controller with per-set round-robin replacement.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   p1_addr_i/p1_data_i : CPU byte address / store data
//   p1_MemRead_i/p1_MemWrite_i : load / store request (both high = store)
//   p1_data_o           : load data (combinational on hit, or in DONE)
//   p1_stall_o          : pipeline hold
//   mem_addr_o/mem_data_o/mem_enable_o/mem_write_o : line memory request
//   mem_data_i/mem_ack_i: refill line and completion pulse
//   dbg_state           : current controller state
// Optional: define DCACHE_STATS_EN to add hit_cnt_o, miss_cnt_o, wb_cnt_o.
module dcache_assoc_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output state_t            dbg_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
  output logic [31:0]       wb_cnt_o
`endif
);

  localparam int OFF_W  = off_w(LINE_W);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
  localparam int BYTE_W = $clog2(WORD_W / 8);
  localparam int SEL_W  = (LINE_W > WORD_W) ? $clog2(LINE_W / WORD_W) : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Memory handshake: mem_enable_o is a registered valid that stays high,
  // with address/data/write stable, until mem_ack_i is seen high on a rising
  // edge; mem_ack_i is a one-cycle pulse and is ignored outside WRITEBACK and
  // REFILL.

  state_t             state;
  logic [WAY_W-1:0]   victim_q;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [SEL_W-1:0]   word_sel;
  logic               req;
  logic               is_store;

  logic [WAYS-1:0]    way_valid;
  logic [WAYS-1:0]    way_dirty;
  logic [TAG_W-1:0]   way_tag  [WAYS];
  logic [LINE_W-1:0]  way_line [WAYS];
  logic [WAYS-1:0]    line_we;
  logic [WAYS-1:0]    word_we;

  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic               found_free;
  logic [WAY_W-1:0]   victim;
  logic [WAY_W-1:0]   rr_cur;
  logic               refill_ack;

  assign idx        = p1_addr_i[OFF_W +: IDX_W];
  assign tag        = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign word_sel   = SEL_W'((p1_addr_i >> BYTE_W) % (LINE_W / WORD_W));
  assign req        = p1_MemRead_i | p1_MemWrite_i;
  assign is_store   = p1_MemWrite_i;
  assign refill_ack = (state == ST_REFILL) && mem_ack_i;
  assign dbg_state  = state;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way_store #(
      .LINE_W(LINE_W), .WORD_W(WORD_W), .SETS(SETS),
      .TAG_W(TAG_W), .IDX_W(IDX_W), .SEL_W(SEL_W)
    ) u_store (
      .clk      (clk_i),
      .rst      (rst_i),
      .idx      (idx),
      .valid    (way_valid[w]),
      .dirty    (way_dirty[w]),
      .tag      (way_tag[w]),
      .line     (way_line[w]),
      .line_we  (line_we[w]),
      .line_tag (tag),
      .line_data(mem_data_i),
      .word_we  (word_we[w]),
      .word_sel (word_sel),
      .word_data(p1_data_i)
    );
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && way_valid[w] && (way_tag[w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest-numbered invalid way, else the set's round-robin pointer.
  always_comb begin
    found_free = 1'b0;
    victim     = rr_cur;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_free && !way_valid[w]) begin
        found_free = 1'b1;
        victim     = WAY_W'(w);
      end
    end
  end

  if (WAYS > 1) begin : g_rr
    logic [WAY_W-1:0] rr_q [SETS];

    // WAYS is a power of two, so the natural wrap is modulo WAYS.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else if (refill_ack) begin
        rr_q[idx] <= rr_q[idx] + 1'b1;
      end
    end

    assign rr_cur = rr_q[idx];
  end else begin : g_no_rr
    assign rr_cur = '0;
  end

  // The refilled line lands in the victim way; stores merge either on an
  // IDLE hit or in DONE, into the line that was just installed.
  always_comb begin
    line_we = '0;
    word_we = '0;
    if (refill_ack) line_we[victim_q] = 1'b1;
    if ((state == ST_IDLE) && req && is_store && hit) word_we[hit_way] = 1'b1;
    if ((state == ST_DONE) && is_store) word_we[victim_q] = 1'b1;
  end

  always_comb begin
    p1_data_o = '0;
    if (state == ST_DONE)
      p1_data_o = way_line[victim_q][word_sel*WORD_W +: WORD_W];
    else if ((state == ST_IDLE) && req && !is_store && hit)
      p1_data_o = way_line[hit_way][word_sel*WORD_W +: WORD_W];
  end

  assign p1_stall_o = ((state == ST_IDLE) && req && !hit) ||
                      (state == ST_WRITEBACK) || (state == ST_REFILL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      victim_q     <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req && !hit) begin
            victim_q     <= victim;
            mem_enable_o <= 1'b1;
            if (way_dirty[victim]) begin
              state       <= ST_WRITEBACK;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {way_tag[victim], idx, {OFF_W{1'b0}}};
              mem_data_o  <= way_line[victim];
            end else begin
              state       <= ST_REFILL;
              mem_write_o <= 1'b0;
              mem_addr_o  <= {tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        ST_WRITEBACK: begin
          // Enable stays high straight into the refill read.
          if (mem_ack_i) begin
            state       <= ST_REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {tag, idx, {OFF_W{1'b0}}};
          end
        end
        ST_REFILL: begin
          if (mem_ack_i) begin
            state        <= ST_DONE;
            mem_enable_o <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      if ((state == ST_IDLE) && req && hit)  hit_cnt_o  <= hit_cnt_o + 32'd1;
      if ((state == ST_IDLE) && req && !hit) miss_cnt_o <= miss_cnt_o + 32'd1;
      if ((state == ST_WRITEBACK) && mem_ack_i) wb_cnt_o <= wb_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
module tb_dcache_assoc_ctrl;
  import dcache_pkg::*;

  localparam int SETS = 16;
  localparam int WAYS = 2;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i, p1_data_i;
  logic         p1_MemRead_i, p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o, mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  state_t       dbg_state;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o, wb_cnt_o;
`endif

  always #5 clk = ~clk;

  dcache_assoc_ctrl #(
    .ADDR_W(32), .WORD_W(32), .LINE_W(256), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_MemRead_i (p1_MemRead_i),
    .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .dbg_state    (dbg_state)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o),
    .wb_cnt_o     (wb_cnt_o)
`endif
  );

  // ---------------- reference model ----------------
  logic [22:0]  m_tag   [SETS][WAYS];
  bit           m_valid [SETS][WAYS];
  bit           m_dirty [SETS][WAYS];
  logic [255:0] m_line  [SETS][WAYS];
  int           m_rr    [SETS];
  logic [255:0] mem_model [logic [31:0]];
  int           n_hit, n_miss, n_wb;

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    end
    n_hit = 0; n_miss = 0; n_wb = 0;
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] la);
    logic [255:0] l;
    if (!mem_model.exists(la)) begin
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
      mem_model[la] = l;
    end
    return mem_model[la];
  endfunction

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           failures = 0;
  bit           chk_on = 0;
  bit           exp_stall, chk_data, exp_mem_en, exp_mem_wr;
  logic [31:0]  exp_data, exp_mem_addr;
  logic [255:0] exp_q [$];          // expected writeback lines, in order
  string        pin_name_q [$];
  logic [31:0]  pin_act_q [$];
  logic [31:0]  pin_exp_q [$];

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    pin_name_q.push_back(name);
    pin_act_q.push_back(act);
    pin_exp_q.push_back(exp);
  endtask

  always @(negedge clk) begin
    while (pin_name_q.size() > 0)
      cmp(pin_name_q.pop_front(), 256'(pin_act_q.pop_front()), 256'(pin_exp_q.pop_front()));
    if (chk_on && !rst_i) begin
      cmp("stall", 256'(p1_stall_o), 256'(exp_stall));
      cmp("mem_enable", 256'(mem_enable_o), 256'(exp_mem_en));
      if (exp_mem_en) begin
        cmp("mem_write", 256'(mem_write_o), 256'(exp_mem_wr));
        cmp("mem_addr", 256'(mem_addr_o), 256'(exp_mem_addr));
      end
      if (chk_data) cmp("p1_data", 256'(p1_data_o), 256'(exp_data));
      if (mem_enable_o && mem_write_o && mem_ack_i) begin
        if (exp_q.size() == 0) cmp("wb_expected", 256'(exp_q.size()), 256'(1));
        else cmp("wb_line", mem_data_o, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit          last_miss, last_wb, en_cont, cap_stall;
  logic [31:0] cap_data, last_wb_addr, last_wb_d0, last_rf_addr, junk_d0;

  task automatic next_cycle();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    p1_MemRead_i = 0; p1_MemWrite_i = 0; p1_addr_i = $urandom();
    exp_stall = 0; exp_mem_en = 0; chk_data = 1; exp_data = '0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Memory responder: random wait, then a one-cycle ack carrying rdata.
  task automatic mem_phase(input logic [255:0] rdata, output logic [31:0] a_seen,
                           output logic [31:0] d0_seen);
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      mem_ack_i = 0;
      @(negedge clk);
      if (!mem_enable_o) en_cont = 0;
      @(posedge clk); #1;
    end
    mem_ack_i = 1; mem_data_i = rdata;
    @(negedge clk);
    if (!mem_enable_o) en_cont = 0;
    a_seen = mem_addr_o; d0_seen = mem_data_o[31:0];
    @(posedge clk); #1;
    mem_ack_i = 0; mem_data_i = '0;
  endtask

  task automatic access(input logic [31:0] a, input bit st, input logic [31:0] wd);
    int s, ws, way, vic;
    bit hit, dirty;
    logic [31:0] la;
    logic [255:0] line;
    s = int'(a[8:5]); ws = int'(a[4:2]); la = {a[31:5], 5'b0};
    hit = 0; way = 0;
    for (int w = 0; w < WAYS; w++)
      if (!hit && m_valid[s][w] && m_tag[s][w] == a[31:9]) begin hit = 1; way = w; end
    p1_addr_i = a; p1_data_i = wd; p1_MemWrite_i = st;
    p1_MemRead_i = st ? 1'($urandom_range(0, 1)) : 1'b1;
    exp_mem_en = 0; chk_data = 1; exp_data = '0;
    if (hit) begin
      exp_stall = 0;
      if (!st) exp_data = m_line[s][way][ws*32 +: 32];
      @(negedge clk);
      cap_stall = p1_stall_o; cap_data = p1_data_o; last_miss = 0;
      @(posedge clk); #1;
      if (st) begin m_line[s][way][ws*32 +: 32] = wd; m_dirty[s][way] = 1; end
      n_hit++;
    end else begin
      last_miss = 1; last_wb = 0; en_cont = 1; n_miss++;
      vic = -1;
      for (int w = 0; w < WAYS; w++) if (vic < 0 && !m_valid[s][w]) vic = w;
      if (vic < 0) vic = m_rr[s];
      dirty = m_valid[s][vic] && m_dirty[s][vic];
      exp_stall = 1;
      next_cycle();
      exp_mem_en = 1;
      if (dirty) begin
        exp_mem_wr = 1; exp_mem_addr = {m_tag[s][vic], a[8:5], 5'b0};
        exp_q.push_back(m_line[s][vic]);
        mem_model[exp_mem_addr] = m_line[s][vic];
        mem_phase('0, last_wb_addr, last_wb_d0);
        last_wb = 1; n_wb++;
      end
      exp_mem_wr = 0; exp_mem_addr = la;
      line = get_line(la);
      mem_phase(line, last_rf_addr, junk_d0);
      m_valid[s][vic] = 1; m_dirty[s][vic] = 0;
      m_tag[s][vic] = a[31:9]; m_line[s][vic] = line;
      m_rr[s] = (m_rr[s] + 1) % WAYS;
      // DONE cycle
      exp_mem_en = 0; exp_stall = 0; chk_data = !st;
      exp_data = line[ws*32 +: 32];
      @(negedge clk);
      cap_stall = p1_stall_o; cap_data = p1_data_o;
      @(posedge clk); #1;
      if (st) begin m_line[s][vic][ws*32 +: 32] = wd; m_dirty[s][vic] = 1; end
    end
    p1_MemRead_i = 0; p1_MemWrite_i = 0;
    exp_stall = 0; exp_mem_en = 0; chk_data = 1; exp_data = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] l;
    logic [31:0]  ra;
    rst_i = 1; p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 0; p1_MemWrite_i = 0;
    mem_ack_i = 0; mem_data_i = '0;
    exp_stall = 0; exp_mem_en = 0; exp_mem_wr = 0; chk_data = 0; exp_data = '0; exp_mem_addr = '0;
    model_reset();
    l = get_line(32'h40); l[31:0] = 32'hDEAD_BEEF; mem_model[32'h40] = l;
    l = get_line(32'h80); l[31:0] = 32'h0BAD_F00D; mem_model[32'h80] = l;

    repeat (3) @(posedge clk);
    #1;
    pin("rst_mem_enable", 32'(mem_enable_o), 32'd0);
    pin("rst_mem_write", 32'(mem_write_o), 32'd0);
    pin("rst_mem_addr", mem_addr_o, 32'd0);
    pin("rst_mem_data", mem_data_o[31:0], 32'd0);
    pin("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_i = 0;
    @(negedge clk);
    pin("rst_stall", 32'(p1_stall_o), 32'd0);
    pin("rst_data", p1_data_o, 32'd0);
    @(posedge clk); #1;
    chk_on = 1;

    // 1: cold load, then hit
    access(32'h40, 0, '0);
    pin("cold_miss", 32'(last_miss), 32'd1);
    pin("cold_refill_addr", last_rf_addr, 32'h40);
    pin("cold_done_stall", 32'(cap_stall), 32'd0);
    pin("cold_done_data", cap_data, 32'hDEAD_BEEF);
    access(32'h40, 0, '0);
    pin("rep_hit", 32'(last_miss), 32'd0);
    pin("rep_stall", 32'(cap_stall), 32'd0);
    pin("rep_data", cap_data, 32'hDEAD_BEEF);

    // 2: associativity and round-robin
    access(32'h0000, 0, '0); pin("a0_miss", 32'(last_miss), 32'd1);
    access(32'h0200, 0, '0); pin("a200_miss", 32'(last_miss), 32'd1);
    access(32'h0000, 0, '0); pin("a0_hit", 32'(last_miss), 32'd0);
    access(32'h0400, 0, '0); pin("a400_miss", 32'(last_miss), 32'd1);
    access(32'h0200, 0, '0); pin("a200_kept", 32'(last_miss), 32'd0);

    // 3: dirty eviction
    access(32'h0000, 1, 32'h1234_5678);
    access(32'h0600, 0, '0);
    pin("a600_clean", 32'(last_wb), 32'd0);
    access(32'h0800, 0, '0);
    pin("wb_seen", 32'(last_wb), 32'd1);
    pin("wb_addr", last_wb_addr, 32'h0);
    pin("wb_word0", last_wb_d0, 32'h1234_5678);
    pin("wb_enable_cont", 32'(en_cont), 32'd1);
    pin("wb_refill_addr", last_rf_addr, 32'h800);
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    pin("stat_hit", hit_cnt_o, 32'd3);
    pin("stat_miss", miss_cnt_o, 32'd7);
    pin("stat_wb", wb_cnt_o, 32'd1);
    @(posedge clk); #1;
`endif

    // 4: write-allocate
    access(32'h0084, 1, 32'hA5A5_A5A5);
    pin("wa_miss", 32'(last_miss), 32'd1);
    access(32'h0084, 0, '0);
    pin("wa_hit", 32'(last_miss), 32'd0);
    pin("wa_data", cap_data, 32'hA5A5_A5A5);
    access(32'h0080, 0, '0);
    pin("wa_other", cap_data, 32'h0BAD_F00D);

    // 5: reset during REFILL
    chk_on = 0;
    p1_addr_i = 32'h0A60; p1_MemRead_i = 1; p1_MemWrite_i = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pin("mid_in_refill", 32'(dbg_state), 32'(ST_REFILL));
    rst_i = 1; #1;
    pin("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    pin("mid_rst_enable", 32'(mem_enable_o), 32'd0);
    p1_MemRead_i = 0;
    @(posedge clk); #1;
    rst_i = 0; model_reset(); exp_q.delete();
    mem_ack_i = 1; mem_data_i = {8{32'hFFFF_0000}};
    @(negedge clk);
    pin("late_ack_state", 32'(dbg_state), 32'(ST_IDLE));
    pin("late_ack_enable", 32'(mem_enable_o), 32'd0);
    @(posedge clk); #1;
    mem_ack_i = 0; mem_data_i = '0;
    @(negedge clk);
    pin("post_ack_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    chk_on = 1;
    access(32'h0A60, 0, '0);
    pin("aborted_line_miss", 32'(last_miss), 32'd1);
    access(32'h0040, 0, '0);
    pin("invalidated_miss", 32'(last_miss), 32'd1);

    // random traffic over a few sets to force evictions
    for (int i = 0; i < 300; i++) begin
      ra = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 5)) << 9) |
           (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
      access(ra, 1'($urandom_range(0, 1)), $urandom());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(1);
    @(negedge clk);
    pin("wb_queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef DCACHE_STATS_EN
    pin("stat_hit_end", hit_cnt_o, 32'(n_hit));
    pin("stat_miss_end", miss_cnt_o, 32'(n_miss));
    pin("stat_wb_end", wb_cnt_o, 32'(n_wb));
`endif
    @(posedge clk); #1;
    idle(2);
    chk_on = 0;
    @(negedge clk);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_assoc_ctrl.md
# dcache_assoc_ctrl

Parametrised set-associative, write-back, write-allocate data cache controller for the MEM stage of the pipelined CPU. It replaces the fixed direct-mapped cache with one configurable in line width, set count and associativity, using per-set round-robin replacement. It keeps the existing CPU-side interface (`p1_*`, combinational hit, `p1_stall_o`) and the 256-bit line memory interface (`mem_*`).

## Interface
- `ADDR_W`, 32: byte address width.
- `WORD_W`, 32: CPU word width.
- `LINE_W`, 256: line width in bits; a power of two and a multiple of `WORD_W`.
- `SETS`, 16: number of sets; a power of two, at least 2.
- `WAYS`, 2: associativity; a power of two, 1 to 8.
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `p1_addr_i` input ADDR_W: byte address, word aligned.
- `p1_data_i` input WORD_W: store data.
- `p1_MemRead_i` input 1: load request.
- `p1_MemWrite_i` input 1: store request.
- `p1_data_o` output WORD_W: load data, combinational.
- `p1_stall_o` output 1: the pipeline must hold while this is high.
- `mem_addr_o` output ADDR_W: line-aligned memory address.
- `mem_data_o` output LINE_W: write-back line.
- `mem_enable_o` output 1: memory request valid.
- `mem_write_o` output 1: 1 means write, 0 means read.
- `mem_data_i` input LINE_W: refill line, valid while `mem_ack_i` is high.
- `mem_ack_i` input 1: one-cycle completion pulse for the current request.

## Operation
**Address split**
- OFF = log2(LINE_W/8) bits, IDX = log2(SETS) bits, TAG = ADDR_W − IDX − OFF.
- The word is selected by `addr[OFF-1:log2(WORD_W/8)]`.

**Requests**
- A request is `p1_MemRead_i | p1_MemWrite_i`. If both are high, the request is treated as a store.
- The CPU holds address, data and request stable while `p1_stall_o` is high.

**Hit**
- Hit means some way in the indexed set is valid and has a matching tag.
- Load hit: `p1_data_o` = the selected word, and `p1_stall_o` = 0 in the same cycle.
- Store hit: the word is written and the dirty bit set at the clock edge.

**Miss: way selection (victim)**
- The victim is the lowest-numbered invalid way.
- If every way is valid, the victim is the set's round-robin pointer. The pointer advances modulo WAYS on every refill of that set.

**State machine**
- IDLE:
  - Request and miss: `p1_stall_o` = 1 combinationally.
  - If the victim is dirty, go to WRITEBACK; otherwise go to REFILL.
- WRITEBACK:
  - `mem_enable_o` = 1, `mem_write_o` = 1, `mem_addr_o` = {victim tag, idx, 0}, `mem_data_o` = victim line (all registered on entry).
  - On `mem_ack_i`, go to REFILL.
- REFILL:
  - `mem_enable_o` = 1, `mem_write_o` = 0, `mem_addr_o` = {req tag, idx, 0}.
  - On `mem_ack_i`, install `mem_data_i` into the victim way, set valid, set tag, clear dirty, advance the pointer, then go to DONE.
- DONE (one cycle):
  - `p1_stall_o` = 0 and the access is served from the installed line. A store merges the word and sets dirty.
  - Go to IDLE.

**Other behaviour**
- `p1_stall_o` = 1 in WRITEBACK and REFILL.
- `mem_ack_i` is ignored in IDLE and DONE.
- `p1_data_o` = 0 when there is no load hit and the state is not DONE.

## Timing
**Reset values**
- All valid, dirty and pointer bits are 0.
- State is IDLE.
- `mem_enable_o`, `mem_write_o`, `mem_addr_o` and `mem_data_o` are 0.
- `p1_stall_o` = 0 when there is no request.

**Latency**
- Hit: 0 extra cycles.
- Clean miss detected in cycle T:
  - `mem_enable_o` rises at T+1.
  - `mem_ack_i` arrives in cycle A ≥ T+1.
  - DONE, with the stall low, is cycle A+1.
- Dirty miss: writeback ack in W, then REFILL from W+1 with `mem_enable_o` held high. Only the address and `mem_write_o` change.

**Boundary cases**
- Reset mid-transfer aborts immediately: all lines are invalidated and any later ack is ignored.
- A request with no hit that arrives in DONE is evaluated in the following IDLE cycle.
- WAYS = 1: pointer logic is removed and the victim is always way 0.

## Configuration
- `DCACHE_STATS_EN` defined: adds 32-bit outputs `hit_cnt_o`, `miss_cnt_o` and `wb_cnt_o`.
  - All three reset to 0 and wrap on overflow.
  - `hit_cnt_o` increments on each IDLE cycle with a request and a hit.
  - `miss_cnt_o` increments on each IDLE-to-WRITEBACK or IDLE-to-REFILL transition.
  - `wb_cnt_o` increments on each writeback ack.
  - DONE cycles are not counted.
- `DCACHE_STATS_EN` undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
**Package `dcache_pkg`**
- State enum: IDLE, WRITEBACK, REFILL, DONE.
- Helper functions for the OFF, IDX and TAG widths.

**Sub-module `dcache_way_store`**
- Instantiated WAYS times.
- Holds the tag, valid, dirty and data arrays for one way.
- Provides a combinational read port, plus a write port for either a line or a word.

**Top level**
- The FSM, hit/victim selection, round-robin pointers and memory interface live in `dcache_assoc_ctrl`.

## Test plan
1. **Reset, then a cold load.** Load from 0x0000_0040 with memory returning a line whose word 0 is 0xDEAD_BEEF.
   - Expect one REFILL read at address 0x40.
   - Expect the stall to drop in DONE with `p1_data_o` = 0xDEAD_BEEF.
   - Expect a repeat load to hit with 0 stall cycles.
2. **Associativity.** SETS = 16, WAYS = 2: load 0x0000, 0x0200 and 0x0000 again.
   - Expect two misses, then a hit.
   - Then load 0x0400: expect it to evict way 0 (pointer value 0).
3. **Dirty eviction.** Store 0x1234_5678 to 0x0000, then miss in set 0 until way 0 is the victim.
   - Expect a WRITEBACK to address 0x0 carrying 0x1234_5678 in bits [31:0].
   - Expect the REFILL that follows with `mem_enable_o` continuously high.
4. **Write-allocate.** Store to uncached 0x0084 with value 0xA5A5_A5A5.
   - Expect a REFILL, then a merge in DONE.
   - Expect a following load of 0x0084 to return 0xA5A5_A5A5 and a load of 0x0080 to return the refilled word.
5. **Reset mid-transfer.** Assert `rst_i` during REFILL, then pulse `mem_ack_i`.
   - Expect the state to stay IDLE with `mem_enable_o` = 0.
   - Expect the next access to the same address to miss.
6. **Stats (`DCACHE_STATS_EN`).** Run scenario 3.
   - Expect `miss_cnt_o`, `hit_cnt_o` and `wb_cnt_o` to match the counts of each event in the sequence.
   - Expect `wb_cnt_o` = 1.
